// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller.
// No logic; types and constants only.
// No flow control.
package pipe_pkg;

    localparam int REG_AW = 5;

    // Execute-stage operand source.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Divider sequencing state.
    typedef enum logic {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Event counter for pipeline performance statistics, wraps at 2^CNT_W.
// Count visible one cycle after the event.
// No backpressure; counts every cycle i_inc is high.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Synchronous clear, otherwise count events with natural wrap.
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline, with divider sequencing.
// Stall, flush and forward outputs are combinational; counters lag one cycle.
// Memory wait freezes every stage; a running divide holds F/D/E until div_done.
module hazard_ctrl #(
    parameter int CNT_W  = 32,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              load_e,
    input  logic              div_e,
    input  logic              pc_src_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic              dmem_req_m,
    input  logic              dmem_ready,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic              div_done,
    output logic              div_start,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import pipe_pkg::*;

    hz_state_t r_state;
    hz_state_t w_state_nxt;
    logic      w_dmem_wait;
    logic      w_lw_stall;
    logic      w_div_hold;

    // M result is newer than W, so it wins; x0 is hardwired and never forwarded.
    function automatic fwd_sel_t fwd_pick(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdm,
        input logic              wem,
        input logic [REG_AW-1:0] rdw,
        input logic              wew
    );
        if (wem && (rdm != '0) && (rdm == rs))
            return FWD_M;
        else if (wew && (rdw != '0) && (rdw == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    assign fwd_a_e = fwd_pick(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    assign fwd_b_e = fwd_pick(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

    assign w_dmem_wait = dmem_req_m && !dmem_ready;
    assign w_lw_stall  = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign w_div_hold  = ((r_state == RUN) && div_e) || ((r_state == DIV_WAIT) && !div_done);

    // State register; reset abandons any divide in flight.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    // Next state and prioritised stall/flush decode; memory wait freezes the FSM too.
    always_comb begin
        w_state_nxt = r_state;
        div_start   = 1'b0;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        flush_w     = 1'b0;

        if (!rst) begin
            if (!w_dmem_wait) begin
                if ((r_state == RUN) && div_e)
                    w_state_nxt = DIV_WAIT;
                else if ((r_state == DIV_WAIT) && div_done)
                    w_state_nxt = RUN;
            end

            if (w_dmem_wait) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (w_div_hold) begin
                stall_f   = 1'b1;
                stall_d   = 1'b1;
                stall_e   = 1'b1;
                flush_m   = 1'b1;
                div_start = (r_state == RUN);
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (w_lw_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (stall_f),
        .o_cnt (stall_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (flush_d),
        .o_cnt (flush_cnt)
    );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush/forward controller for the 5-stage pipeline (F/D/E/M/W).
- Drives the enable (stall) and clear (flush) inputs of every inter-stage pipeline register and the execute-stage operand forwarding muxes.
- Sequences the multi-cycle divider through a start/done handshake and freezes the pipeline on data-memory wait states.
- Keeps stall and flush event counters for performance analysis.

Parameters:
- CNT_W, 32, width of the performance counters.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rs1_d, rs2_d  in  REG_AW  source regs of the instruction in D
- rs1_e, rs2_e, rd_e  in  REG_AW  source/dest regs of the instruction in E
- load_e  in  1  instruction in E is a load
- div_e  in  1  instruction in E is a divide/remainder
- pc_src_e  in  1  taken branch/jump resolved in E
- rd_m  in  REG_AW  dest reg in M
- reg_write_m  in  1  M writes rd_m
- dmem_req_m  in  1  M is issuing a data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- rd_w  in  REG_AW  dest reg in W
- reg_write_w  in  1  W writes rd_w
- div_done  in  1  divider result valid (single-cycle pulse)
- div_start  out  1  one-cycle divider start pulse
- stall_f, stall_d, stall_e, stall_m  out  1  hold the PC / pipeline register feeding that stage
- flush_d, flush_e, flush_m, flush_w  out  1  clear the register feeding that stage (bubble)
- fwd_a_e, fwd_b_e  out  2  forwarding select: 00 regfile, 01 W result, 10 M ALU result
- stall_cnt  out  CNT_W  cycles with stall_f asserted
- flush_cnt  out  CNT_W  cycles with flush_d asserted

Behaviour:
- Reset: state RUN; stall_cnt and flush_cnt = 0. All stall/flush/div_start outputs are 0 while rst is high. fwd_* is purely combinational and unaffected by reset.
- Forwarding (combinational), shown for fwd_a_e; fwd_b_e is identical using rs2_e:
  - 10 if reg_write_m && rd_m != 0 && rd_m == rs1_e.
  - else 01 if reg_write_w && rd_w != 0 && rd_w == rs1_e.
  - else 00.
  - M has priority over W. Register x0 is never forwarded.
- Hazard terms (combinational):
  - dmem_wait = dmem_req_m && !dmem_ready.
  - lw_stall = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d).
  - div_hold = (state==RUN && div_e) || (state==DIV_WAIT && !div_done).
- Priority 1, dmem_wait:
  - stall_f, stall_d, stall_e, stall_m = 1; flush_w = 1. All other outputs are 0.
  - div_start is suppressed. The FSM holds its state; a pending div_done is not lost because the divider holds done until the pulse is consumed.
- Priority 2, div_hold:
  - stall_f, stall_d, stall_e = 1; flush_m = 1.
  - pc_src_e and lw_stall are ignored while E is held.
- Priority 3, pc_src_e:
  - flush_d = 1 and flush_e = 1.
  - lw_stall is suppressed, so the redirect PC is loaded.
- Priority 4, lw_stall:
  - stall_f = 1, stall_d = 1, flush_e = 1. Exactly one bubble per load-use pair.
- FSM (states RUN, DIV_WAIT):
  - RUN -> DIV_WAIT when div_e && !dmem_wait. div_start = 1 for that single cycle.
  - DIV_WAIT -> RUN on div_done && !dmem_wait. Stalls drop in the div_done cycle, so E->M captures the quotient at the next edge.
  - No div_start is ever issued from DIV_WAIT.
  - div_done arriving while in RUN is ignored.
- Counters:
  - stall_cnt increments on each non-reset cycle with stall_f = 1.
  - flush_cnt increments on each non-reset cycle with flush_d = 1.
  - Both wrap modulo 2^CNT_W.
- Reset mid-divide: state returns to RUN. The divider is reset by the same rst, so no stale div_done is expected.

Decomposition:
- pipe_pkg contains:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - hz_state_t enum: RUN, DIV_WAIT.
  - REG_AW constant.
- Sub-module hazard_perf_cnt, instantiated twice: a CNT_W wrapping counter with inc and synchronous rst.

Test Plan:
- Forwarding: rs1_e = 5, rd_m = 5 with reg_write_m = 1, rd_w = 5 with reg_write_w = 1 -> fwd_a_e = 10. Drop reg_write_m -> 01. Set rd_m = rd_w = rs1_e = 0 -> 00.
- Load-use: load_e = 1, rd_e = 7, rs2_d = 7 -> exactly one cycle of stall_f = stall_d = flush_e = 1. Next cycle, with load_e = 0, all stalls are 0 and stall_cnt has advanced by 1.
- Branch plus load-use in the same cycle: pc_src_e = 1, lw_stall true -> flush_d = flush_e = 1, stall_f = 0, flush_cnt +1.
- Divide: div_e = 1 -> div_start pulses one cycle. Hold div_done low for 4 cycles -> stall_f/d/e = 1 and flush_m = 1 for 5 cycles total. div_done = 1 -> stalls drop that cycle, state RUN, no second div_start.
- Memory wait during divide: in DIV_WAIT, assert dmem_req_m = 1, dmem_ready = 0 for 3 cycles with div_done = 1 -> stall_m = 1 and flush_w = 1, state remains DIV_WAIT. When dmem_ready = 1 -> return to RUN.
- Reset mid-DIV_WAIT: assert rst for 1 cycle -> all stall/flush/div_start outputs = 0, state RUN, stall_cnt = flush_cnt = 0.
